// File: rtl/lsu.sv
// Multi-cycle load/store unit: one op at a time, req/ack data bus, load write-back and pipeline hold.
// Optional LSU_ALIGN_CHECK_EN: trap misaligned H/W accesses to ERR instead of issuing them on the bus.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        we_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rd_wdata_o,
    output logic [4:0]  rd_waddr_o,
    output logic        reg_wen_o,
    output logic        hold_flag_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] rd_wdata_q;
    logic [4:0]  rd_waddr_q;
    logic        reg_wen_q;
    logic        err_q;
    logic        misalign_d;
    logic [31:0] load_data_d;

    // func3[1] selects word, else func3[0] selects half, else byte.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1])
            return 4'b1111;
        else if (f3[0])
            return a[1] ? 4'b1100 : 4'b0011;
        return 4'b0001 << a;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1])
            return wd;
        else if (f3[0])
            return {2{wd[15:0]}};
        return {4{wd[7:0]}};
    endfunction

    // Halfwords only look at addr[1], so an unchecked odd H address reads the aligned half.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [1:0]  sh;
        logic [31:0] s;
        if (f3[1])
            return rdata;
        sh = f3[0] ? {a[1], 1'b0} : a;
        s  = rdata >> {sh, 3'b000};
        if (f3[0])
            return f3[2] ? {16'h0000, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return f3[2] ? {24'h000000, s[7:0]} : {{24{s[7]}}, s[7:0]};
    endfunction

`ifdef LSU_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1])
            return a != 2'b00;
        else if (f3[0])
            return a[0];
        return 1'b0;
    endfunction

    assign misalign_d = is_misaligned(func3_i, addr_i[1:0]);
`else
    assign misalign_d = 1'b0;
`endif

    assign load_data_d = load_extract(func3_q, off_q, mem_rdata_i);

    assign req_ready_o = (state_q == S_IDLE);
    assign hold_flag_o = (state_q != S_IDLE) | req_valid_i;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign reg_wen_o   = reg_wen_q;
    assign err_o       = err_q;

    // Request latch: only consumed in BUS/DONE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid_i) begin
            we_q    <= we_i;
            func3_q <= func3_i;
            off_q   <= addr_i[1:0];
            rd_q    <= rd_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            rd_wdata_q  <= 32'h0;
            rd_waddr_q  <= 5'd0;
            reg_wen_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            reg_wen_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_wdata_q <= 32'h0;
            rd_waddr_q <= 5'd0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (misalign_d) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_BUS;
                            cnt_q       <= 8'd0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_wdata_q <= we_i ? store_data(func3_i, wdata_i) : 32'h0;
                            mem_wstrb_q <= we_i ? store_strb(func3_i, addr_i[1:0]) : 4'h0;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack_i || cnt_q == TO_LAST) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                        mem_wstrb_q <= 4'h0;
                    end
                    if (mem_ack_i) begin
                        state_q <= S_DONE;
                        if (!we_q && rd_q != 5'd0) begin
                            reg_wen_q  <= 1'b1;
                            rd_waddr_q <= rd_q;
                            rd_wdata_q <= load_data_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner sequences, randomized ops vs a byte-level model.
module tb_lsu;
    localparam int TIMEOUT = 16;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, we_i, mem_ack_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic [4:0]  rd_addr_i;
    logic        req_ready_o, mem_req_o, mem_we_o, reg_wen_o, hold_flag_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rd_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [4:0]  rd_waddr_o;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .we_i(we_i), .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .rd_wdata_o(rd_wdata_o), .rd_waddr_o(rd_waddr_o),
        .reg_wen_o(reg_wen_o), .hold_flag_o(hold_flag_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_rdw;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: treats the bus word as four bytes and applies the access rules arithmetically.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned b[4];
        int unsigned idx, v;
        for (int i = 0; i < 4; i++) b[i] = (rdata >> (8 * i)) & 32'hFF;
        if (f3[1]) return rdata;
        if (f3[0]) begin
            idx = addr & 32'd2;
            v = b[idx] + 256 * b[idx + 1];
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        idx = addr & 32'd3;
        v = b[idx];
        if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned s;
        if (f3[1]) s = 15;
        else if (f3[0]) s = 3 << (addr & 32'd2);
        else s = 1 << (addr & 32'd3);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1]) return wd;
        if (f3[0]) return (wd & 32'hFFFF) * 32'h00010001;
        return (wd & 32'hFF) * 32'h01010101;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
        if (!ALIGN) return 1'b0;
        if (f3[1]) return (addr & 32'd3) != 0;
        if (f3[0]) return (addr & 32'd1) != 0;
        return 1'b0;
    endfunction

    task automatic bus_chk(input string nm, input logic we, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wd);
        chk({nm, ".mem_req"}, 32'(mem_req_o), 32'd1);
        chk({nm, ".mem_we"}, 32'(mem_we_o), 32'(we));
        chk({nm, ".mem_addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
        chk({nm, ".wstrb"}, 32'(mem_wstrb_o), 32'(strb));
        if (we) chk({nm, ".mem_wdata"}, mem_wdata_o, wd);
        chk({nm, ".hold"}, 32'(hold_flag_o), 32'd1);
        chk({nm, ".ready"}, 32'(req_ready_o), 32'd0);
    endtask

    // Issues one op in the current cycle; dly = BUS cycles before ack, dly >= TIMEOUT means no ack.
    task automatic run_op(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int dly, input logic [31:0] rdata, input logic exp_err,
                          input logic [31:0] exp_rdw, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd);
        logic wen;
        int   nbus;
        wen = !we && rd != 5'd0 && !exp_err;
        req_valid_i = 1'b1; we_i = we; func3_i = f3; addr_i = addr; wdata_i = wd; rd_addr_i = rd;
        #1;
        chk({nm, ".acc_ready"}, 32'(req_ready_o), 32'd1);
        chk({nm, ".acc_hold"}, 32'(hold_flag_o), 32'd1);
        step();
        req_valid_i = 1'b0; wdata_i = $urandom; addr_i = $urandom;
        if (exp_err) begin
            #1;
            chk({nm, ".mis_err"}, 32'(err_o), 32'd1);
            chk({nm, ".mis_req"}, 32'(mem_req_o), 32'd0);
            chk({nm, ".mis_wen"}, 32'(reg_wen_o), 32'd0);
            step();
            chk({nm, ".mis_ready"}, 32'(req_ready_o), 32'd1);
            chk({nm, ".mis_err_clr"}, 32'(err_o), 32'd0);
            return;
        end
        nbus = (dly >= TIMEOUT) ? TIMEOUT : dly;
        for (int k = 0; k < nbus; k++) begin
            bus_chk(nm, we, addr, exp_strb, exp_wd);
            step();
        end
        if (dly >= TIMEOUT) begin
            chk({nm, ".to_err"}, 32'(err_o), 32'd1);
            chk({nm, ".to_req"}, 32'(mem_req_o), 32'd0);
            chk({nm, ".to_wen"}, 32'(reg_wen_o), 32'd0);
            step();
            chk({nm, ".to_ready"}, 32'(req_ready_o), 32'd1);
            chk({nm, ".to_err_clr"}, 32'(err_o), 32'd0);
            chk({nm, ".to_wen2"}, 32'(reg_wen_o), 32'd0);
            return;
        end
        bus_chk(nm, we, addr, exp_strb, exp_wd);
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        chk({nm, ".wen"}, 32'(reg_wen_o), 32'(wen));
        chk({nm, ".waddr"}, 32'(rd_waddr_o), wen ? 32'(rd) : 32'd0);
        chk({nm, ".wdata"}, rd_wdata_o, wen ? exp_rdw : 32'd0);
        chk({nm, ".done_req"}, 32'(mem_req_o), 32'd0);
        chk({nm, ".done_err"}, 32'(err_o), 32'd0);
        chk({nm, ".done_hold"}, 32'(hold_flag_o), 32'd1);
        step();
        chk({nm, ".idle_ready"}, 32'(req_ready_o), 32'd1);
        chk({nm, ".idle_hold"}, 32'(hold_flag_o), 32'd0);
        chk({nm, ".idle_wen"}, 32'(reg_wen_o), 32'd0);
        chk({nm, ".idle_wdata"}, rd_wdata_o, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; we_i = 1'b0; func3_i = 3'd0; addr_i = 32'h0;
        wdata_i = 32'h0; rd_addr_i = 5'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;

        vecs[0]  = '{1'b0, 3'b010, 32'h1000_0004, 32'h0, 5'd5, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h1000_0003, 32'h0, 5'd1, 0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h1000_0003, 32'h0, 5'd1, 0, 32'h80FF_0000, 1'b0, 32'h0000_0080, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h1000_0002, 32'h0, 5'd2, 1, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h1000_0002, 32'h0, 5'd2, 1, 32'h80FF_0000, 1'b0, 32'h0000_80FF, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 3'b000, 32'h1000_0002, 32'h1234_56A5, 5'd3, 1, 32'h0, 1'b0, 32'h0, 4'b0100, 32'hA5A5_A5A5};
        vecs[6]  = '{1'b1, 3'b001, 32'h1000_0002, 32'h1234_BEEF, 5'd3, 0, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hBEEF_BEEF};
        vecs[7]  = '{1'b1, 3'b010, 32'h2000_0000, 32'hCAFE_F00D, 5'd4, 3, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 3'b010, 32'h2000_0008, 32'h0, 5'd0, 0, 32'h1111_2222, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 3'b000, 32'h3000_0001, 32'h0, 5'd9, 0, 32'h0000_7F00, 1'b0, 32'h0000_007F, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h1000_0001, 32'h0, 5'd7, 0, 32'h1122_3344, ALIGN, 32'h1122_3344, 4'h0, 32'h0};

        // Reset state
        step(); step();
        chk("rst.ready", 32'(req_ready_o), 32'd1);
        chk("rst.hold", 32'(hold_flag_o), 32'd0);
        chk("rst.mem_req", 32'(mem_req_o), 32'd0);
        chk("rst.wen", 32'(reg_wen_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   vecs[i].rd, vecs[i].dly, vecs[i].rdata, vecs[i].err, vecs[i].exp_rdw,
                   vecs[i].exp_strb, vecs[i].exp_wd);

        // Timeout: no ack ever
        run_op("timeout", 1'b0, 3'b010, 32'h4000_0000, 32'h0, 5'd6, TIMEOUT, 32'h0, 1'b0,
               32'h0, 4'h0, 32'h0);

        // Stray ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        step();
        mem_ack_i = 1'b0;
        chk("idle_ack.wen", 32'(reg_wen_o), 32'd0);
        chk("idle_ack.ready", 32'(req_ready_o), 32'd1);
        chk("idle_ack.req", 32'(mem_req_o), 32'd0);

        // Reset mid-BUS, then a stray ack, then a normal load
        req_valid_i = 1'b1; we_i = 1'b0; func3_i = 3'b010; addr_i = 32'h5000_0010; rd_addr_i = 5'd8;
        step();
        req_valid_i = 1'b0;
        step();
        chk("midrst.pre_req", 32'(mem_req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.req", 32'(mem_req_o), 32'd0);
        chk("midrst.addr", mem_addr_o, 32'd0);
        chk("midrst.ready", 32'(req_ready_o), 32'd1);
        chk("midrst.hold0", 32'(hold_flag_o), 32'd0);
        req_valid_i = 1'b1;
        #1;
        chk("midrst.hold1", 32'(hold_flag_o), 32'd1);
        req_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        step();
        mem_ack_i = 1'b0;
        chk("stray.wen", 32'(reg_wen_o), 32'd0);
        chk("stray.err", 32'(err_o), 32'd0);
        chk("stray.req", 32'(mem_req_o), 32'd0);
        chk("stray.ready", 32'(req_ready_o), 32'd1);
        step();
        chk("stray.wen2", 32'(reg_wen_o), 32'd0);
        run_op("post_rst", 1'b0, 3'b010, 32'h6000_0020, 32'h0, 5'd11, 1, 32'h0BAD_F00D, 1'b0,
               32'h0BAD_F00D, 4'h0, 32'h0);

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rdata;
            logic [4:0]  rd;
            int          dly, sel;
            we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, we ? 2 : 4);
            case (sel)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            addr = $urandom; wd = $urandom; rdata = $urandom;
            rd = 5'($urandom_range(0, 31));
            dly = $urandom_range(0, 4);
            run_op($sformatf("rnd%0d", n), we, f3, addr, wd, rd, dly, rdata, m_mis(f3, addr),
                   m_load(f3, addr, rdata), we ? m_strb(f3, addr) : 4'h0, m_wd(f3, wd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit sitting directly downstream of the execute stage. It accepts one memory operation at a time, using the address that execute computes as base plus offset. It runs a request/acknowledge transaction on the data bus and writes load results back to the register file. While an operation is in flight it holds the pipeline through ctrl.

## Interface
- TIMEOUT, 16: max cycles spent in BUS without `mem_ack_i` before abort; legal range 2..255
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute presents a memory op this cycle
- req_ready_o  out  1  combinational, = (state==IDLE)
- we_i  in  1  1 store, 0 load
- func3_i  in  3  access width/sign: 000 B, 001 H, 01x/11x W, bit2 = unsigned (loads only)
- addr_i  in  32  effective byte address (base+offset)
- wdata_i  in  32  store data (rs2)
- rd_addr_i  in  5  load destination
- mem_req_o  out  1  bus request, held high through the whole BUS state
- mem_we_o  out  1  bus write
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_wstrb_o  out  4  byte strobes, 0 for loads
- mem_ack_i  in  1  bus completion; `mem_rdata_i` valid in the same cycle
- mem_rdata_i  in  32  read word
- rd_wdata_o  out  32  load result
- rd_waddr_o  out  5  load destination
- reg_wen_o  out  1  one-cycle write-back pulse
- hold_flag_o  out  1  to ctrl: (state!=IDLE) | req_valid_i
- err_o  out  1  one-cycle pulse on misalign or timeout

## Operation
- States: IDLE, BUS, DONE, ERR.
- IDLE:
  - On req_valid_i, latch we/func3/addr/wdata/rd_addr.
  - A misaligned op goes to ERR; all other ops go to BUS.
  - Misaligned means: H with addr[0]=1, or W with addr[1:0]!=0.
- BUS:
  - mem_req_o=1; bus outputs are taken from the latched request and held constant.
  - On mem_ack_i, capture mem_rdata_i and go to DONE.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 with no ack, go to ERR.
- DONE, one cycle:
  - For a load with rd!=0, reg_wen_o=1 with the extracted data.
  - A store, or a load to x0, gives reg_wen_o=0.
  - Then go to IDLE.
- ERR, one cycle: err_o=1, no write-back and no bus activity. Then go to IDLE.
- Store lanes:
  - B: wdata = {4{wdata[7:0]}}, wstrb = 0001<<addr[1:0].
  - H: wdata = {2{wdata[15:0]}}, wstrb = 0011<<{addr[1],1'b0}.
  - W: wstrb = 1111.
- Load extract:
  - shifted = rdata >> (8*addr[1:0]).
  - B/H are sign-extended from bit 7/15 when func3[2]=0, zero-extended otherwise.
  - W passes through unchanged.
- mem_ack_i outside BUS is ignored.
- The timeout counter clears on entering BUS.
- Reset (any state, any cycle):
  - state goes to IDLE and the counter goes to 0.
  - All registered outputs go to 0, and req_ready_o=1.
  - hold_flag_o follows req_valid_i.
  - An in-flight bus request is dropped without completion.

## Timing
- Accept at cycle T (req_valid_i & IDLE).
- BUS starts at T+1. With ack in the same cycle as the request, the earliest case is ack at T+1.
- DONE, and therefore reg_wen_o, at T+2. IDLE and req_ready_o=1 at T+3.
- Load-to-write-back latency is 2 + (ack wait cycles).
- Misaligned op: err_o at T+1, IDLE at T+2.
- Timeout: err_o at T+1+TIMEOUT, with mem_req_o high for exactly TIMEOUT cycles.
- hold_flag_o is combinational, so ctrl stalls upstream in the accept cycle itself. It deasserts in the cycle the FSM is back in IDLE with req_valid_i low.
- rd_wdata_o, rd_waddr_o, reg_wen_o and err_o are registered and valid only while their pulse is high; they are 0 otherwise.

## Configuration
- LSU_ALIGN_CHECK_EN defined: misaligned ops are detected as above and trap to ERR (err_o pulse, no bus access).
- LSU_ALIGN_CHECK_EN undefined:
  - No misalign detection; every op goes to BUS.
  - H uses addr[1] only, ignoring addr[0]; W ignores addr[1:0].
  - err_o pulses only on timeout.

## Test plan
- LW at 0x1000_0004, rd=5, ack 3 cycles after request with rdata 0xDEADBEEF:
  - mem_addr_o=0x1000_0004, wstrb=0, mem_req_o high for 3 cycles.
  - Then reg_wen_o=1, rd_waddr_o=5, rd_wdata_o=0xDEADBEEF.
  - hold_flag_o stays high throughout.
- LB and LBU at addr 0x...03 with rdata 0x80FF_0000:
  - LB gives rd_wdata_o=0xFFFF_FF80; LBU gives 0x0000_0080.
  - LH at 0x...02 gives 0xFFFF_80FF.
- SB at 0x...02 with wdata 0x1234_56A5:
  - mem_wdata_o=0xA5A5_A5A5, mem_wstrb_o=0100, mem_we_o=1.
  - reg_wen_o never asserts.
- Misaligned LW at 0x...01:
  - With LSU_ALIGN_CHECK_EN: err_o pulse at T+1 and mem_req_o never asserts.
  - Without it: bus read at 0x...00 completes normally.
- No ack with TIMEOUT=16: err_o pulses after 16 request cycles, then req_ready_o=1 and no write-back.
- rst low mid-BUS, then a stray ack after release:
  - All outputs 0, FSM IDLE, stray ack ignored.
  - A following LW completes normally.
